divider4_seq: RTL
=================

DIVIDER4_SEQ -- requirements
Module: divider4_seq

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 4 bits.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock; all state changes on posedge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-005 start  input  1  request; accepted only when ready=1.
REQ-006 signed_mode  input  1  operand interpretation: 0 = unsigned, 1 = two's complement; sampled with start.
REQ-007 x  input  4  dividend, sampled on accepted start.
REQ-008 y  input  4  divisor, sampled on accepted start.
REQ-009 ready  output  1  high in IDLE and DONE; the block accepts start.
REQ-010 valid  output  1  single-cycle pulse; results are valid.
REQ-011 q  output  4  quotient.
REQ-012 r  output  4  remainder.
REQ-013 v  output  1  signed overflow flag.
REQ-014 dz  output  1  divide-by-zero flag.

Function
REQ-015 FSM states SHALL be IDLE, CALC, DONE.
  - IDLE->CALC on start.
  - CALC->DONE after exactly 4 cycles.
  - DONE->CALC on start, else DONE->IDLE.
REQ-016 An accepted start on cycle N SHALL cause valid=1 on cycle N+5 exactly, for every operand combination, including dz and v cases.
REQ-017 Operand capture:
  - The block SHALL capture x, y and signed_mode in registers on an accepted start.
  - Inputs changing during CALC SHALL NOT affect the result.
REQ-018 Start with ready=0 (CALC) SHALL be ignored without effect.
REQ-019 CALC SHALL perform one restoring-division step per cycle, MSB first.
  - Each step computes a trial subtract of the divisor magnitude from the partial remainder.
  - The block SHALL use 5-bit internal magnitudes so that |-8| = 8 is representable.
REQ-020 Unsigned mode: q = x / y and r = x mod y.
REQ-021 Signed mode: the result SHALL truncate toward zero.
  - The block SHALL divide magnitudes.
  - q SHALL be negated when the operand signs differ.
  - r SHALL take the sign of x, with r=0 when the magnitude remainder is 0.
REQ-022 Signed overflow: x=4'b1000, y=4'b1111 with signed_mode=1 SHALL give q=4'b1000, r=4'b0000, v=1.
  - v SHALL be 0 in every other case.
REQ-023 Divide by zero: y=4'b0000 SHALL give dz=1, q=4'b1111, r=x, and v=0, in either mode.
REQ-024 Output hold:
  - q, r, v and dz SHALL update only on the cycle valid asserts.
  - They SHALL hold until the next result.
REQ-025 valid SHALL be high for exactly one cycle per accepted start.
REQ-026 Back-to-back operation: a start during the DONE cycle SHALL be accepted, so the next valid arrives 5 cycles later with no bubble state.

Reset
REQ-027 rst_n=0 at a posedge SHALL force:
  - state=IDLE;
  - ready=1, valid=0;
  - q=0, r=0, v=0, dz=0;
  - all internal registers cleared.
REQ-028 Reset in any state, including mid-CALC, SHALL abort the operation with no valid pulse.
  - Reset SHALL take priority over a simultaneous start.
REQ-029 A start on the first cycle with rst_n=1 after reset SHALL be accepted.

Verification
REQ-030 Unsigned: signed_mode=0, x=1101, y=0011, start at N -> valid at N+5, q=0100, r=0001, v=0, dz=0.
REQ-031 Signed, mixed signs: signed_mode=1, both with start at N -> valid at N+5.
  - x=0100, y=1101 -> q=1111, r=0001.
  - x=1001, y=0010 -> q=1101, r=1111.
REQ-032 Signed overflow: signed_mode=1, x=1000, y=1111 -> q=1000, r=0000, v=1, at N+5.
REQ-033 Divide by zero: x=0101, y=0000 -> dz=1, q=1111, r=0101, at N+5; the same result in both modes.
REQ-034 Busy, back-to-back and reset:
  - start held high through CALC -> ignored; back-to-back start in DONE -> next valid 5 cycles later.
  - rst_n=0 at N+2 -> no valid; outputs 0; ready=1 the next cycle.

Source files
------------

// File: rtl/divider4_seq.sv
// divider4_seq: 4-bit sequential restoring divider, unsigned or two's complement.
// An accepted start produces a one-cycle valid pulse five cycles later. The four
// CALC cycles each retire one quotient bit, MSB first. Signed operands are
// divided as magnitudes and the signs are applied to the final result.
module divider4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       signed_mode,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       ready,
  output logic       valid,
  output logic [3:0] q,
  output logic [3:0] r,
  output logic       v,
  output logic       dz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [1:0] step_cnt;
  logic [3:0] dvd;      // dividend magnitude, shifts left; quotient bits enter at the LSB
  logic [4:0] pr;       // partial remainder
  logic [4:0] dvs;      // divisor magnitude; 5 bits so |-8| = 8 is representable
  logic [3:0] x_reg;    // raw dividend, returned as the remainder on divide-by-zero
  logic       neg_q;
  logic       neg_r;
  logic       dz_reg;
  logic       ovf_reg;

  logic       accept;
  logic       x_neg;
  logic       y_neg;
  logic [4:0] x_mag;
  logic [4:0] y_mag;
  logic [4:0] pr_sh;
  logic [5:0] trial;
  logic       fit;
  logic [4:0] next_pr;
  logic [3:0] next_dvd;
  logic [3:0] q_fin;
  logic [3:0] r_fin;

  assign ready  = (state == IDLE) || (state == DONE);
  assign valid  = (state == DONE);
  assign accept = start && ready;

  // Operand magnitudes; sign-extend before negating so that -8 maps to +8.
  assign x_neg = signed_mode && x[3];
  assign y_neg = signed_mode && y[3];
  assign x_mag = x_neg ? (5'd0 - {x[3], x}) : {1'b0, x};
  assign y_mag = y_neg ? (5'd0 - {y[3], y}) : {1'b0, y};

  // One restoring step plus the sign fix-up applied to the final step's result.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    pr_sh    = {pr[3:0], dvd[3]};
    trial    = {1'b0, pr_sh} - {1'b0, dvs};
    fit      = ~trial[5];
    next_pr  = pr_sh;
    next_dvd = {dvd[2:0], fit};
    if (fit) begin
      next_pr = trial[4:0];
    end
    q_fin = neg_q ? (4'd0 - next_dvd) : next_dvd;
    r_fin = neg_r ? (4'd0 - next_pr[3:0]) : next_pr[3:0];
    if (dz_reg) begin
      q_fin = 4'b1111;
      r_fin = x_reg;
    end
  end

  // Control FSM and iteration datapath.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      // NOTE: every internal register is cleared in reset, including the datapath, so no stale operand survives an abort.
      state    <= IDLE;
      step_cnt <= 2'd0;
      dvd      <= 4'd0;
      pr       <= 5'd0;
      dvs      <= 5'd0;
      x_reg    <= 4'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_reg   <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          dvd      <= next_dvd;
          pr       <= next_pr;
          step_cnt <= step_cnt + 2'd1;
          if (step_cnt == 2'd3) begin
            state <= DONE;
          end
        end
        default: begin
          state <= accept ? CALC : IDLE;
        end
      endcase
      if (accept) begin
        step_cnt <= 2'd0;
        dvd      <= x_mag[3:0];
        pr       <= 5'd0;
        dvs      <= y_mag;
        x_reg    <= x;
        neg_q    <= x_neg ^ y_neg;
        neg_r    <= x_neg;
        dz_reg   <= (y == 4'd0);
        ovf_reg  <= signed_mode && (x == 4'b1000) && (y == 4'b1111);
      end
    end
  end

  // Result registers load only on the transition into DONE and hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q  <= 4'd0;
      r  <= 4'd0;
      v  <= 1'b0;
      dz <= 1'b0;
    end else if (state == CALC && step_cnt == 2'd3) begin
      q  <= q_fin;
      r  <= r_fin;
      v  <= ovf_reg;
      dz <= dz_reg;
    end
  end

endmodule
